bit_logic_unit: RTL and testbench

- Registered, multi-operation bitwise logic unit for the ALU, parametrised in WIDTH. Successor to the single-op combinational bitwise blocks.
- Executes AND/OR/XOR/NOR/XNOR/ANDN/PASS_A in one cycle and POPCNT iteratively, CHUNK bits per cycle.
- Uses a valid/ready handshake on both sides, drives the standard 4-bit status vector, and keeps a sticky status register for the ALU control path.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/bit_logic_unit_popcount.sv | 19 +
 rtl/bit_logic_unit.sv | 173 +++++++++++++++++
 tb/tb_bit_logic_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status bit positions,
// bitwise op codes and the logic-unit FSM states.
package alu_pkg;

  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NOR    = 3'd3,
    OP_XNOR   = 3'd4,
    OP_ANDN   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_POPCNT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_logic_unit_popcount.sv
// Combinational population count of one CHUNK-bit slice.
// Feeds the iterative POPCNT accumulator in the logic unit.
module chunk_popcount #(
  parameter int CHUNK = 4,
  parameter int CW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CW-1:0]    count
);

  // sum the set bits of the slice
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/bit_logic_unit.sv
// Registered multi-op bitwise unit with iterative POPCNT,
// valid/ready on both sides and a sticky status register.
module bit_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic [3:0]       sticky_status,
  input  logic             clr_sticky
);

  localparam int NIT = WIDTH / CHUNK;
  localparam int IW  = $clog2(NIT + 1);
  localparam int AW  = $clog2(WIDTH + 1);
  localparam int CW  = $clog2(CHUNK + 1);

  if (WIDTH < 4 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("bit_logic_unit: WIDTH must be >= 4 and a multiple of CHUNK");
  end

  function automatic logic [3:0] status_of(input logic [WIDTH-1:0] r);
    status_of = '0;
    status_of[ST_NEG]  = r[WIDTH-1];
    status_of[ST_ZERO] = (r == '0);
  endfunction

  state_e           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [AW-1:0]    acc, acc_d;
  logic [IW-1:0]    iter, iter_d;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    sum;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] load_val;
  logic             load;
  logic             free;
  logic             accept;
  logic             xfer_out;
  op_e              opc;

  assign opc      = op_e'(op);
  assign free     = !out_valid || out_ready;
  assign in_ready = !rst && (state == IDLE) && free;
  assign accept   = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;
  assign sum      = acc + AW'(cnt);

  chunk_popcount #(
    .CHUNK(CHUNK),
    .CW   (CW)
  ) u_cnt (
    .bits (shreg[CHUNK-1:0]),
    .count(cnt)
  );

  // single-cycle bitwise result for the presented op
  always_comb begin
    logic_res = operand1;
    unique case (opc)
      OP_AND:    logic_res = operand1 & operand2;
      OP_OR:     logic_res = operand1 | operand2;
      OP_XOR:    logic_res = operand1 ^ operand2;
      OP_NOR:    logic_res = ~(operand1 | operand2);
      OP_XNOR:   logic_res = ~(operand1 ^ operand2);
      OP_ANDN:   logic_res = operand1 & ~operand2;
      OP_PASS_A: logic_res = operand1;
      OP_POPCNT: logic_res = operand1;
      default:   logic_res = operand1;
    endcase
  end

  // FSM next state, POPCNT datapath and result-load request
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    acc_d    = acc;
    iter_d   = iter;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (opc == OP_POPCNT) begin
            shreg_d = operand1;
            acc_d   = '0;
            iter_d  = IW'(NIT);
            state_d = COUNT;
          end else begin
            load     = 1'b1;
            load_val = logic_res;
          end
        end
      end
      COUNT: begin
        acc_d   = sum;
        shreg_d = shreg >> CHUNK;
        iter_d  = iter - 1'b1;
        if (iter == IW'(1)) begin
          if (free) begin
            load     = 1'b1;
            load_val = WIDTH'(sum);
            state_d  = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (free) begin
          load     = 1'b1;
          load_val = WIDTH'(acc);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and POPCNT working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      iter  <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      acc   <= acc_d;
      iter  <= iter_d;
    end
  end

  // output register: load new result or drop valid on transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      statusOut <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_val;
      statusOut <= status_of(load_val);
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

  // sticky status: a delivery on the clear cycle wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_status <= '0;
    end else if (xfer_out) begin
      sticky_status <= clr_sticky ? statusOut
                                  : (sticky_status | statusOut);
    end else if (clr_sticky) begin
      sticky_status <= '0;
    end
  end

endmodule

// File: tb/tb_bit_logic_unit.sv
// Self-checking bench for bit_logic_unit (WIDTH=16, CHUNK=4):
// directed scenarios plus randomized traffic against a reference model.
module tb_bit_logic_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  status_o;
  logic [3:0]  sticky;
  logic        clr_sticky;

  int total = 0;
  int bad   = 0;

  bit_logic_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .operand1     (a),
    .operand2     (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .statusOut    (status_o),
    .sticky_status(sticky),
    .clr_sticky   (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_res(input int o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
    int n;
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x | y);
      4: return ~(x ^ y);
      5: return x & ~y;
      6: return x;
      default: begin
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(x[i]);
        return 16'(n);
      end
    endcase
  endfunction

  function automatic logic [3:0] ref_st(input logic [15:0] r);
    return {r[15], (r == 16'd0), 2'b00};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive(input int o, input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    op = 3'(o);
    a = x;
    b = y;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    smp;
    total++;
    if ({out_valid, in_ready, result, status_o, sticky} !== 26'd0) begin
      bad++;
      $display("FAIL reset: ov=%b ir=%b res=%h st=%b sticky=%b want all 0",
               out_valid, in_ready, result, status_o, sticky);
    end
    step;
    rst = 1'b0;
  endtask

  task automatic test_xor;
    step;
    out_ready = 1'b1;
    drive(2, 16'hF0F0, 16'h0FF0);
    smp;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL xor_ready: got %b want 1", in_ready);
    end
    step;
    in_valid = 1'b0;
    smp;
    total++;
    if (out_valid !== 1'b1 || result !== 16'hFF00 || status_o !== 4'b1000) begin
      bad++;
      $display("FAIL xor: ov=%b res=%h st=%b want 1 ff00 1000",
               out_valid, result, status_o);
    end
  endtask

  task automatic test_back_to_back;
    step;
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    drive(2, 16'hA5A5, 16'hA5A5);
    step;
    drive(3, 16'h0000, 16'h0000);
    smp;
    total++;
    if (result !== 16'h0000 || status_o !== 4'b0100 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_xor: res=%h st=%b ir=%b want 0000 0100 1",
               result, status_o, in_ready);
    end
    step;
    in_valid = 1'b0;
    smp;
    total++;
    if (out_valid !== 1'b1 || result !== 16'hFFFF || status_o !== 4'b1000) begin
      bad++;
      $display("FAIL b2b_nor: ov=%b res=%h st=%b want 1 ffff 1000",
               out_valid, result, status_o);
    end
    step;
    smp;
    total++;
    if (out_valid !== 1'b0 || sticky !== 4'b1100) begin
      bad++;
      $display("FAIL b2b_sticky: ov=%b sticky=%b want 0 1100", out_valid, sticky);
    end
  endtask

  task automatic test_popcnt;
    int n;
    step;
    drive(7, 16'hFFFF, 16'h1234);
    step;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL pop_busy%0d: ir=%b ov=%b want 0 0", k, in_ready, out_valid);
      end
      step;
    end
    smp;
    total++;
    if (out_valid !== 1'b1 || result !== 16'h0010 || status_o !== 4'b0000) begin
      bad++;
      $display("FAIL pop_ffff: ov=%b res=%h st=%b want 1 0010 0000",
               out_valid, result, status_o);
    end
    step;
    drive(7, 16'h0000, 16'hFFFF);
    step;
    in_valid = 1'b0;
    n = 0;
    smp;
    while (!out_valid && n < 10) begin
      step;
      smp;
      n++;
    end
    total++;
    if (n !== 4 || result !== 16'h0000 || status_o !== 4'b0100) begin
      bad++;
      $display("FAIL pop_zero: wait=%0d res=%h st=%b want 4 0000 0100",
               n, result, status_o);
    end
  endtask

  task automatic test_backpressure;
    step;
    out_ready = 1'b0;
    drive(0, 16'h00FF, 16'h0F0F);
    step;
    drive(1, 16'h1200, 16'h0034);
    for (int k = 0; k < 2; k++) begin
      smp;
      total++;
      if (out_valid !== 1'b1 || result !== 16'h000F || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b res=%h ir=%b want 1 000f 0",
                 k, out_valid, result, in_ready);
      end
      step;
    end
    out_ready = 1'b1;
    smp;
    total++;
    if (in_ready !== 1'b1 || result !== 16'h000F) begin
      bad++;
      $display("FAIL bp_release: ir=%b res=%h want 1 000f", in_ready, result);
    end
    step;
    in_valid = 1'b0;
    smp;
    total++;
    if (out_valid !== 1'b1 || result !== 16'h1234 || status_o !== 4'b0000) begin
      bad++;
      $display("FAIL bp_or: ov=%b res=%h st=%b want 1 1234 0000",
               out_valid, result, status_o);
    end
    step;
    smp;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_hold;
    step;
    out_ready = 1'b0;
    drive(7, 16'h8001, 16'h0000);
    step;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready%0d: got %b want 0", k, in_ready);
      end
      step;
    end
    out_ready = 1'b1;
    smp;
    total++;
    if (out_valid !== 1'b1 || result !== 16'h0002 || status_o !== 4'b0000) begin
      bad++;
      $display("FAIL hold_res: ov=%b res=%h st=%b want 1 0002 0000",
               out_valid, result, status_o);
    end
    step;
    smp;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midpop;
    step;
    out_ready = 1'b1;
    drive(6, 16'h8000, 16'h0000);
    step;
    drive(7, 16'h1234, 16'h0000);
    step;
    in_valid = 1'b0;
    smp;
    total++;
    if (sticky[3] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_sticky: sticky=%b want 1xxx", sticky);
    end
    step;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, result, status_o, sticky} !== 26'd0) begin
      bad++;
      $display("FAIL mid_reset: ov=%b ir=%b res=%h st=%b sticky=%b want all 0",
               out_valid, in_ready, result, status_o, sticky);
    end
    step;
    step;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_output%0d: ov=%b want 0", k, out_valid);
      end
      step;
    end
    drive(6, 16'h8000, 16'h0000);
    step;
    in_valid = 1'b0;
    step;
    smp;
    total++;
    if (sticky !== 4'b1000) begin
      bad++;
      $display("FAIL clr_pre: sticky=%b want 1000", sticky);
    end
    step;
    drive(2, 16'h5555, 16'h5555);
    step;
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    smp;
    total++;
    if (sticky !== 4'b0100) begin
      bad++;
      $display("FAIL clr_with_xfer: sticky=%b want 0100", sticky);
    end
    step;
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    smp;
    total++;
    if (sticky !== 4'b0000) begin
      bad++;
      $display("FAIL clr_alone: sticky=%b want 0000", sticky);
    end
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    logic [15:0] e;
    logic [3:0]  sm;
    int sent;
    int cyc;
    step;
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    sm = 4'b0000;
    sent = 0;
    cyc = 0;
    while ((sent < 40 || q.size() > 0) && cyc < 2000) begin
      in_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 11) == 0);
      smp;
      total++;
      if (sticky !== sm) begin
        bad++;
        $display("FAIL rnd_sticky c%0d: got %b want %b", cyc, sticky, sm);
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_spurious c%0d: res=%h with nothing pending", cyc, result);
        end else begin
          e = q.pop_front();
          if (result !== e || status_o !== ref_st(e)) begin
            bad++;
            $display("FAIL rnd_result c%0d: res=%h st=%b want %h %b",
                     cyc, result, status_o, e, ref_st(e));
          end
          sm = clr_sticky ? ref_st(e) : (sm | ref_st(e));
        end
      end else if (clr_sticky) begin
        sm = 4'b0000;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_res(int'(op), a, b));
        sent++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    total++;
    if (cyc >= 2000 || q.size() != 0) begin
      bad++;
      $display("FAIL rnd_timeout: sent=%0d pending=%0d want 40 0", sent, q.size());
    end
    step;
  endtask

  initial begin
    test_reset;
    test_xor;
    test_back_to_back;
    test_popcnt;
    test_backpressure;
    test_hold;
    test_random;
    test_reset_midpop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
